// File: rtl/sra_unit.sv
// sra_unit: registered 16-bit arithmetic shift-right slice of the CPU ALU.
//
// Ports:
//   clk        system clock, rising-edge state updates
//   rst_n      asynchronous active-low reset (deassertion synchronized externally)
//   in_valid   A/Shamt are valid this cycle
//   A          operand, two's complement
//   Shamt      unsigned shift amount 0..WIDTH-1
//   ShiftedRA  registered A >>> Shamt
//   out_valid  ShiftedRA and the flags carry a new result this cycle
//   shift_out  last bit shifted out, A[Shamt-1]; 0 when Shamt == 0
//   zero       ShiftedRA == 0
//   neg        ShiftedRA[WIDTH-1]
//
// The core is a logarithmic barrel shifter (1/2/4/8). It runs on a vector one
// bit wider than the operand, with a guard bit appended below the LSB: after
// shifting by n the guard position holds A[n-1] (or the appended 0 for n == 0),
// which gives shift_out without a separate mux tree.

module sra_stage #(
    parameter int W = 16,
    parameter int S = 1
) (
    input  logic [W:0] din,
    input  logic       en,
    output logic [W:0] dout
);
    assign dout = en ? {{S{din[W]}}, din[W:S]} : din;
endmodule

module sra_unit #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [SHW-1:0]   Shamt,
    output logic [WIDTH-1:0] ShiftedRA,
    output logic             out_valid,
    output logic             shift_out,
    output logic             zero,
    output logic             neg
);
    // stg[k] is the operand (plus guard bit) after stages 0..k-1.
    logic [SHW:0][WIDTH:0] stg;

    assign stg[0] = {A, 1'b0};

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        sra_stage #(
            .W (WIDTH),
            .S (1 << k)
        ) u_stage (
            .din  (stg[k]),
            .en   (Shamt[k]),
            .dout (stg[k+1])
        );
    end

    logic [WIDTH-1:0] res_d, res_q;
    logic             so_d, so_q;
    logic             zero_d, zero_q;
    logic             neg_d, neg_q;
    logic             vld_d, vld_q;

    // Flags are derived from the same value that is loaded into res_q, so they
    // always agree with ShiftedRA; they hold together with it when idle.
    always_comb begin
        res_d  = res_q;
        so_d   = so_q;
        zero_d = zero_q;
        neg_d  = neg_q;
        vld_d  = in_valid;
        if (in_valid) begin
            res_d  = stg[SHW][WIDTH:1];
            so_d   = stg[SHW][0];
            zero_d = (stg[SHW][WIDTH:1] == '0);
            neg_d  = stg[SHW][WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q  <= '0;
            so_q   <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            res_q  <= res_d;
            so_q   <= so_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
            vld_q  <= vld_d;
        end
    end

    assign ShiftedRA = res_q;
    assign shift_out = so_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_sra_unit.sv
module tb_sra_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] A = '0;
    logic [3:0]  Shamt = '0;
    logic [15:0] ShiftedRA;
    logic        out_valid, shift_out, zero, neg;

    int vectors = 0;
    int errors  = 0;

    sra_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .Shamt     (Shamt),
        .ShiftedRA (ShiftedRA),
        .out_valid (out_valid),
        .shift_out (shift_out),
        .zero      (zero),
        .neg       (neg)
    );

    always #5 clk = ~clk;

    // Reference model: signed shift by the language operator, last shifted-out
    // bit by plain integer arithmetic, flags from the resulting value.
    logic [15:0] m_res = '0;
    logic        m_so = 1'b0, m_zero = 1'b0, m_neg = 1'b0, m_vld = 1'b0;

    function automatic logic [15:0] ref_sra(input logic [15:0] a, input int sh);
        logic signed [15:0] s;
        s = a;
        return 16'(s >>> sh);
    endfunction

    function automatic logic ref_so(input logic [15:0] a, input int sh);
        int v;
        v = int'(a);
        if (sh == 0) return 1'b0;
        return logic'((v / (1 << (sh - 1))) % 2);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res <= '0; m_so <= 1'b0; m_zero <= 1'b0; m_neg <= 1'b0; m_vld <= 1'b0;
        end else begin
            m_vld <= in_valid;
            if (in_valid) begin
                m_res  <= ref_sra(A, int'(Shamt));
                m_so   <= ref_so(A, int'(Shamt));
                m_zero <= (ref_sra(A, int'(Shamt)) == 16'h0);
                m_neg  <= ref_sra(A, int'(Shamt)) >= 16'h8000;
            end
        end
    end

    task automatic cmp(input string name, input logic [19:0] act, input logic [19:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got res=%h so=%b z=%b n=%b v=%b, expected res=%h so=%b z=%b n=%b v=%b",
                     name, act[19:4], act[3], act[2], act[1], act[0],
                     exp[19:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Cycle-by-cycle compare of the DUT against the model (or reset values).
    always @(negedge clk) begin
        if (!rst_n)
            cmp("reset_hold", {ShiftedRA, shift_out, zero, neg, out_valid}, 20'h0);
        else
            cmp("model", {ShiftedRA, shift_out, zero, neg, out_valid},
                {m_res, m_so, m_zero, m_neg, m_vld});
    end

    // Inputs change on the falling edge; the next rising edge captures them.
    task automatic step(input logic v, input logic [15:0] a, input logic [3:0] sh);
        @(negedge clk);
        in_valid = v; A = a; Shamt = sh;
    endtask

    // Hand-computed expectation checked against both DUT and model.
    task automatic lit(input string name, input logic [15:0] r, input logic so,
                       input logic z, input logic n, input logic v);
        cmp({name, "_dut"}, {ShiftedRA, shift_out, zero, neg, out_valid}, {r, so, z, n, v});
        cmp({name, "_model"}, {m_res, m_so, m_zero, m_neg, m_vld}, {r, so, z, n, v});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        lit("reset_state", 16'h0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(0, 16'h0, 4'd0);
        step(0, 16'h0, 4'd0);
        lit("idle_after_reset", 16'h0000, 0, 0, 0, 0);

        step(1, 16'h0028, 4'd9);
        step(1, 16'h8001, 4'd1);
        lit("pos_to_zero", 16'h0000, 0, 1, 0, 1);
        step(1, 16'h8000, 4'd15);
        lit("neg_shift1", 16'hC000, 1, 0, 1, 1);
        step(1, 16'h7FFF, 4'd15);
        lit("neg_sat", 16'hFFFF, 0, 0, 1, 1);
        step(1, 16'h1234, 4'd0);
        lit("pos_sat", 16'h0000, 1, 1, 0, 1);
        step(0, 16'hAAAA, 4'd3);
        lit("shamt0", 16'h1234, 0, 0, 0, 1);
        step(0, 16'h5555, 4'd7);
        lit("hold1", 16'h1234, 0, 0, 0, 0);
        step(1, 16'hF0F0, 4'd4);
        lit("hold2", 16'h1234, 0, 0, 0, 0);
        step(1, 16'h0F0F, 4'd8);
        lit("b2b_first", 16'hFF0F, 0, 0, 1, 1);
        step(1, 16'hFFFF, 4'd15);
        lit("b2b_second", 16'h000F, 0, 0, 0, 1);
        step(0, 16'h0, 4'd0);
        lit("all_ones", 16'hFFFF, 1, 0, 1, 1);

        // Every shift amount with random operands and occasional idle cycles.
        for (int sh = 0; sh < 16; sh++) begin
            for (int r = 0; r < 6; r++) begin
                step(($urandom_range(0, 3) != 0), 16'($urandom), 4'(sh));
            end
        end

        // Asynchronous reset mid-stream: outputs clear without a clock edge.
        step(1, 16'h8421, 4'd2);
        step(1, 16'h9000, 4'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 lit("async_reset", 16'h0000, 0, 0, 0, 0);
        step(1, 16'hC3C3, 4'd5);
        step(1, 16'hC3C3, 4'd5);
        @(negedge clk);
        lit("reset_ignores_valid", 16'h0000, 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1, 16'h8000, 4'd3);
        step(0, 16'h0, 4'd0);
        lit("first_after_reset", 16'hF000, 0, 0, 1, 1);

        for (int r = 0; r < 40; r++)
            step(1'b1, 16'($urandom), 4'($urandom_range(0, 15)));
        step(0, 16'h0, 4'd0);
        step(0, 16'h0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/sra_unit.md
Name: sra_unit

Overview:
- Registered 16-bit arithmetic shift-right unit for the 16-bit CPU datapath (ALU shift slice).
- Takes operand A and a 4-bit shift amount, then produces A >>> Shamt with sign fill.
- Result and status flags are registered one clock after a valid input.
- Internally a 4-stage logarithmic barrel shifter (shift by 1/2/4/8) feeding an output register.

Parameters:
- WIDTH, 16, operand/result width; the design is verified only at 16.
- SHW, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/Shamt are valid this cycle.
- A  input  16  operand, two's complement.
- Shamt  input  4  shift amount, 0..15, unsigned.
- ShiftedRA  output  16  registered result A >>> Shamt.
- out_valid  output  1  ShiftedRA and flags are updated with a new result.
- shift_out  output  1  last bit shifted out (A[Shamt-1]); 0 when Shamt=0.
- zero  output  1  ShiftedRA == 0.
- neg  output  1  ShiftedRA[15].

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed): ShiftedRA=0, out_valid=0, shift_out=0, zero=0, neg=0. All outputs stay at these values while rst_n is low.
- Combinational core: stage k (k=0..3) shifts right by 2^k when Shamt[k]=1. Vacated MSBs are filled with A[15] (sign extension).
- The result is identical to a signed arithmetic right shift for every A and every Shamt in 0..15.
- shift_out = A[Shamt-1] for Shamt>=1, and 0 for Shamt=0.
- Latency: on a rising edge with in_valid=1, register the result, shift_out, zero and neg; out_valid=1 in the following cycle.
- On a rising edge with in_valid=0: out_valid goes to 0; ShiftedRA and the flags hold their previous values.
- Back-to-back valid inputs are accepted every cycle (throughput 1/cycle). There is no stall or backpressure.
- Shamt=0: ShiftedRA=A, shift_out=0.
- Shamt=15: ShiftedRA is all copies of A[15] (0x0000 or 0xFFFF).
- Positive operands saturate toward 0; negative operands saturate toward 0xFFFF (-1), never 0.
- zero and neg are computed from the registered result, so they are consistent with ShiftedRA in the same cycle.
- Reset asserted mid-stream: outputs clear immediately. After rst_n deasserts, the first valid input produces a result one cycle later.
- rst_n deassertion is synchronized externally; no internal reset synchronizer is provided.

Test Plan:
- A=40 (0x0028), Shamt=9, in_valid=1 -> next cycle ShiftedRA=0x0000, zero=1, neg=0, shift_out=0, out_valid=1.
- A=0x8001, Shamt=1 -> ShiftedRA=0xC000, neg=1, zero=0, shift_out=1.
- A=0x8000, Shamt=15 -> ShiftedRA=0xFFFF, neg=1, shift_out=0; A=0x7FFF, Shamt=15 -> ShiftedRA=0x0000, zero=1, shift_out=1.
- A=0x1234, Shamt=0 -> ShiftedRA=0x1234, shift_out=0; then in_valid=0 for 2 cycles -> out_valid=0, ShiftedRA holds 0x1234.
- Back-to-back: A=0xF0F0 with Shamt=4, then A=0x0F0F with Shamt=8 on consecutive cycles -> ShiftedRA=0xFF0F then 0x000F on consecutive cycles, each with out_valid=1.
- Exhaustive: random A over all Shamt 0..15 compared against a signed >>> reference model. Pull rst_n low mid-stream -> all outputs 0 immediately.
